// File: rtl/soc_system_sysid_pkg.sv
// Shared definitions for the system-ID checker.
//   - sysid_state_e : checker FSM state encoding
//   - SYSID_ADDR_*  : word addresses inside the system-ID slave
//   - SYSID_*_DEFAULT : default expected ID and build timestamp
package soc_system_sysid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StLatId,
    StRdTs,
    StLatTs,
    StDone
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_EXPECTED_ID_DEFAULT = 32'hACD51302;
  localparam logic [31:0] SYSID_EXPECTED_TS_DEFAULT = 32'h55F060DF;

endpackage

// File: rtl/soc_system_sysid_rd_seq.sv
// Single-read handshake helper for the system-ID checker.
// Detects read acceptance, counts the fixed read latency, counts stall cycles and
// flags a timeout, and raises a one-cycle capture strobe when read data is valid.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   in_rd            : FSM is in a read-request state (avm_read is high)
//   in_lat           : FSM is waiting out the read latency
//   avm_waitrequest  : interconnect stall
//   accept           : read request accepted this cycle
//   capture          : avm_readdata is valid this cycle
//   stall_timeout    : stall limit reached this cycle
module soc_system_sysid_rd_seq #(
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_rd,
  input  logic in_lat,
  input  logic avm_waitrequest,
  output logic accept,
  output logic capture,
  output logic stall_timeout
);

  localparam logic [15:0] StallLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LatLast   = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic        lat_last;

  always_comb begin
    accept        = in_rd & ~avm_waitrequest;
    // Fires on the stall that brings the count to TIMEOUT_CYCLES.
    stall_timeout = in_rd & avm_waitrequest & (stall_cnt_q == StallLast);
    // Any non-stall cycle (accept, or not in a read state) clears the count, so
    // every read-request state starts from zero.
    stall_cnt_d   = (in_rd & avm_waitrequest) ? stall_cnt_q + 16'd1 : 16'd0;
    lat_last      = in_lat & (lat_cnt_q == LatLast);
    lat_cnt_d     = (in_lat & ~lat_last) ? lat_cnt_q + 2'd1 : 2'd0;
    capture       = (READ_LATENCY == 0) ? accept : lat_last;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 16'd0;
      lat_cnt_q   <= 2'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

endmodule

// File: rtl/soc_system_sysid_checker.sv
// System-ID checker: Avalon-MM read master that reads the ID (address 0) and build
// timestamp (address 1) from the system-ID slave after reset or on request, and
// compares them with build-time expected values.
// Optional feature macro: SYSID_CHECK_PERIODIC_EN (periodic re-check every
// PERIOD_CYCLES cycles in DONE, plus a sticky mismatch flag). Without it the
// check is re-run only by start and mismatch_sticky is tied to 0.
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   start               : one-cycle request to re-run the check (honoured in DONE only)
//   avm_address         : 0 = ID word, 1 = timestamp word
//   avm_read            : read request
//   avm_waitrequest     : interconnect stall
//   avm_readdata        : slave read data
//   id_value, ts_value  : captured words
//   busy                : check in progress
//   done                : last check finished (level)
//   match               : both words as expected (valid while done)
//   timeout             : last check aborted by a stall
//   mismatch_sticky     : a failed check has occurred since reset
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID_DEFAULT,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS_DEFAULT,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned PERIOD_CYCLES  = 1000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout,
  output logic        mismatch_sticky
);

  // An out-of-range configuration never leaves IDLE, so it cannot report a match.
  localparam bit ParamsOk = (READ_LATENCY <= 32'd3) && (TIMEOUT_CYCLES >= 32'd1) &&
                            (TIMEOUT_CYCLES <= 32'd65535) && (PERIOD_CYCLES >= 32'd1);

  sysid_state_e state_q, state_d;
  logic [31:0]  id_q, id_d, ts_q, ts_d;
  logic         match_q, match_d, timeout_q, timeout_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic         read_q, read_d, addr_q, addr_d;
  logic         in_rd, in_lat, accept, capture, stall_timeout;
  logic         cap_is_id, enter_done, restart;

  assign in_rd  = (state_q == StRdId) || (state_q == StRdTs);
  assign in_lat = (state_q == StLatId) || (state_q == StLatTs);

  soc_system_sysid_rd_seq #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd_seq (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_rd          (in_rd),
    .in_lat         (in_lat),
    .avm_waitrequest(avm_waitrequest),
    .accept         (accept),
    .capture        (capture),
    .stall_timeout  (stall_timeout)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ts_d      = ts_q;
    match_d   = match_q;
    timeout_d = timeout_q;
    cap_is_id = (state_q == StRdId) || (state_q == StLatId);

    unique case (state_q)
      StIdle: begin
        if (ParamsOk) state_d = StRdId;
      end
      StRdId: begin
        if (stall_timeout) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else if (accept) begin
          state_d = (READ_LATENCY == 0) ? StRdTs : StLatId;
        end
      end
      StLatId: begin
        if (capture) state_d = StRdTs;
      end
      StRdTs: begin
        if (stall_timeout) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else if (accept) begin
          state_d = (READ_LATENCY == 0) ? StDone : StLatTs;
        end
      end
      StLatTs: begin
        if (capture) state_d = StDone;
      end
      StDone: begin
        if (restart) begin
          state_d   = StRdId;
          match_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      if (cap_is_id) id_d = avm_readdata;
      else           ts_d = avm_readdata;
    end

    // Compare uses the words as they will stand after this edge, so the final
    // capture and the DONE entry can share a cycle.
    enter_done = (state_d == StDone) && (state_q != StDone);
    if (enter_done) begin
      match_d = (id_d == EXPECTED_ID) && (ts_d == EXPECTED_TS) && !timeout_d;
    end

    // Status and bus outputs are registered from the next state.
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
    read_d = (state_d == StRdId) || (state_d == StRdTs);
    addr_d = (state_d == StRdTs) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      id_q      <= 32'd0;
      ts_q      <= 32'd0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      read_q    <= 1'b0;
      addr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
    end
  end

`ifdef SYSID_CHECK_PERIODIC_EN
  localparam logic [31:0] PeriodLast = 32'(PERIOD_CYCLES - 1);

  logic [31:0] period_cnt_q, period_cnt_d;
  logic        period_hit;
  logic        sticky_q, sticky_d;

  always_comb begin
    period_hit   = (state_q == StDone) && (period_cnt_q == PeriodLast);
    period_cnt_d = ((state_q == StDone) && !(start | period_hit)) ? period_cnt_q + 32'd1 : 32'd0;
    sticky_d     = sticky_q | (enter_done & ~match_d);
  end

  assign restart         = start | period_hit;
  assign mismatch_sticky = sticky_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt_q <= 32'd0;
      sticky_q     <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      sticky_q     <= sticky_d;
    end
  end
`else
  assign restart         = start;
  assign mismatch_sticky = 1'b0;
`endif

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match       = match_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Directed bench for soc_system_sysid_checker.
// dut_a: READ_LATENCY=0, TIMEOUT_CYCLES=8, zero-latency slave model.
// dut_b: READ_LATENCY=2, TIMEOUT_CYCLES=8, slave model returning data 2 cycles after accept.
// dut_c (only with SYSID_CHECK_PERIODIC_EN): PERIOD_CYCLES=16, free-running.
module tb_soc_system_sysid_checker;

  localparam logic [31:0] ExpId = 32'hACD51302;
  localparam logic [31:0] ExpTs = 32'h55F060DF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // dut_a signals
  logic        start_a = 1'b0, wait_a = 1'b0;
  logic        addr_a, read_a, busy_a, done_a, match_a, tmo_a, sticky_a;
  logic [31:0] rdata_a, id_a, ts_a;
  logic [31:0] id_word_a = ExpId;
  logic [31:0] ts_word_a = ExpTs;
  assign rdata_a = addr_a ? ts_word_a : id_word_a;

  // dut_b signals
  logic        start_b = 1'b0, wait_b = 1'b0;
  logic        addr_b, read_b, busy_b, done_b, match_b, tmo_b, sticky_b;
  logic [31:0] rdata_b, id_b, ts_b;
  logic        p0_v, p0_a, p1_v, p1_a;
  assign rdata_b = p1_v ? (p1_a ? ExpTs : ExpId) : 32'hDEADBEEF;

  // Latency-2 slave: data valid only in the cycle two edges after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_v <= 1'b0; p0_a <= 1'b0; p1_v <= 1'b0; p1_a <= 1'b0;
    end else begin
      p0_v <= read_b & ~wait_b;
      p0_a <= addr_b;
      p1_v <= p0_v;
      p1_a <= p0_a;
    end
  end

  soc_system_sysid_checker #(
    .READ_LATENCY  (0),
    .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clock(clk), .reset_n(rst_n), .start(start_a),
    .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wait_a),
    .avm_readdata(rdata_a), .id_value(id_a), .ts_value(ts_a),
    .busy(busy_a), .done(done_a), .match(match_a), .timeout(tmo_a),
    .mismatch_sticky(sticky_a)
  );

  soc_system_sysid_checker #(
    .READ_LATENCY  (2),
    .TIMEOUT_CYCLES(8)
  ) dut_b (
    .clock(clk), .reset_n(rst_n), .start(start_b),
    .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wait_b),
    .avm_readdata(rdata_b), .id_value(id_b), .ts_value(ts_b),
    .busy(busy_b), .done(done_b), .match(match_b), .timeout(tmo_b),
    .mismatch_sticky(sticky_b)
  );

`ifdef SYSID_CHECK_PERIODIC_EN
  logic        addr_c, read_c, busy_c, done_c, match_c, tmo_c, sticky_c;
  logic [31:0] rdata_c, id_c, ts_c;
  assign rdata_c = addr_c ? ExpTs : ExpId;

  soc_system_sysid_checker #(
    .READ_LATENCY (0),
    .PERIOD_CYCLES(16)
  ) dut_c (
    .clock(clk), .reset_n(rst_n), .start(1'b0),
    .avm_address(addr_c), .avm_read(read_c), .avm_waitrequest(1'b0),
    .avm_readdata(rdata_c), .id_value(id_c), .ts_value(ts_c),
    .busy(busy_c), .done(done_c), .match(match_c), .timeout(tmo_c),
    .mismatch_sticky(sticky_c)
  );
`endif

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({done_a, match_a, tmo_a, busy_a, read_a, addr_a, sticky_a} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags_a: got %b expected 0000000",
               {done_a, match_a, tmo_a, busy_a, read_a, addr_a, sticky_a});
    end
    checks++;
    if (id_a !== 32'd0 || ts_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_words_a: got %h/%h expected 0/0", id_a, ts_a);
    end
    checks++;
    if ({done_b, match_b, tmo_b, busy_b, read_b, addr_b, sticky_b} !== 7'b0 ||
        id_b !== 32'd0 || ts_b !== 32'd0) begin
      errors++;
      $display("FAIL reset_b: got flags %b words %h/%h expected all 0",
               {done_b, match_b, tmo_b, busy_b, read_b, addr_b, sticky_b}, id_b, ts_b);
    end
    repeat (2) tick();
  endtask

  // Auto-start after reset release; dut_a done on 3rd clock, dut_b on 7th.
  task automatic test_zero_wait();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({done_a, busy_a, read_a, addr_a} !== 4'b0111) begin
      errors++;
      $display("FAIL autostart_rd_ts_a: got done/busy/read/addr %b expected 0111",
               {done_a, busy_a, read_a, addr_a});
    end
    tick();
    checks++;
    if ({done_a, match_a, tmo_a, busy_a, read_a} !== 5'b11000) begin
      errors++;
      $display("FAIL autostart_done_a: got done/match/tmo/busy/read %b expected 11000",
               {done_a, match_a, tmo_a, busy_a, read_a});
    end
    checks++;
    if (id_a !== ExpId || ts_a !== ExpTs) begin
      errors++;
      $display("FAIL autostart_words_a: got %h/%h expected %h/%h", id_a, ts_a, ExpId, ExpTs);
    end
    repeat (3) tick();
    checks++;
    if (done_b !== 1'b0) begin
      errors++;
      $display("FAIL lat2_not_done_early_b: got done %b expected 0", done_b);
    end
    tick();
    checks++;
    if ({done_b, match_b, tmo_b} !== 3'b110 || id_b !== ExpId || ts_b !== ExpTs) begin
      errors++;
      $display("FAIL lat2_done_b: got done/match/tmo %b words %h/%h expected 110 %h/%h",
               {done_b, match_b, tmo_b}, id_b, ts_b, ExpId, ExpTs);
    end
  endtask

`ifdef SYSID_CHECK_PERIODIC_EN
  // Continues the count from reset release: DONE entered at clock 3, restart at 19.
  task automatic test_periodic();
    repeat (11) tick();
    checks++;
    if ({busy_c, done_c} !== 2'b01) begin
      errors++;
      $display("FAIL period_before_c: got busy/done %b expected 01", {busy_c, done_c});
    end
    tick();
    checks++;
    if ({busy_c, done_c, read_c, addr_c} !== 4'b1010) begin
      errors++;
      $display("FAIL period_restart_c: got busy/done/read/addr %b expected 1010",
               {busy_c, done_c, read_c, addr_c});
    end
  endtask
`endif

  task automatic test_id_mismatch();
    id_word_a = 32'hACD51303;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if ({done_a, match_a, busy_a, read_a, addr_a} !== 5'b00110) begin
      errors++;
      $display("FAIL restart_rd_id_a: got done/match/busy/read/addr %b expected 00110",
               {done_a, match_a, busy_a, read_a, addr_a});
    end
    tick();
    checks++;
    if ({read_a, addr_a} !== 2'b11) begin
      errors++;
      $display("FAIL restart_rd_ts_a: got read/addr %b expected 11", {read_a, addr_a});
    end
    tick();
    checks++;
    if ({done_a, match_a, tmo_a} !== 3'b100 || id_a !== 32'hACD51303) begin
      errors++;
      $display("FAIL id_mismatch_a: got done/match/tmo %b id %h expected 100 acd51303",
               {done_a, match_a, tmo_a}, id_a);
    end
    checks++;
`ifdef SYSID_CHECK_PERIODIC_EN
    if (sticky_a !== 1'b1) begin
      errors++;
      $display("FAIL sticky_a: got %b expected 1", sticky_a);
    end
`else
    if (sticky_a !== 1'b0) begin
      errors++;
      $display("FAIL sticky_a: got %b expected 0", sticky_a);
    end
`endif
    id_word_a = ExpId;
  endtask

  task automatic test_start_while_busy();
    start_a = 1'b1;
    tick();                       // RD_ID
    start_a = 1'b0;
    tick();                       // RD_TS
    wait_a = 1'b1;
    start_a = 1'b1;               // seen in RD_TS while stalled
    tick();
    start_a = 1'b0;
    checks++;
    if ({busy_a, done_a, read_a, addr_a} !== 4'b1011) begin
      errors++;
      $display("FAIL busy_start_ignored_a: got busy/done/read/addr %b expected 1011",
               {busy_a, done_a, read_a, addr_a});
    end
    wait_a = 1'b0;
    tick();
    checks++;
    if ({done_a, match_a, busy_a} !== 3'b110) begin
      errors++;
      $display("FAIL busy_done_a: got done/match/busy %b expected 110",
               {done_a, match_a, busy_a});
    end
    repeat (3) tick();
    checks++;
    if ({done_a, busy_a, read_a} !== 3'b100) begin
      errors++;
      $display("FAIL start_not_queued_a: got done/busy/read %b expected 100",
               {done_a, busy_a, read_a});
    end
  endtask

  task automatic test_timeout();
    start_a = 1'b1;
    wait_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({read_a, addr_a, done_a} !== 3'b100) begin
        errors++;
        $display("FAIL stall_hold_a[%0d]: got read/addr/done %b expected 100", i,
                 {read_a, addr_a, done_a});
      end
      tick();
    end
    checks++;
    if ({done_a, tmo_a, match_a, busy_a, read_a} !== 5'b11000 || id_a !== ExpId) begin
      errors++;
      $display("FAIL timeout_a: got done/tmo/match/busy/read %b id %h expected 11000 %h",
               {done_a, tmo_a, match_a, busy_a, read_a}, id_a, ExpId);
    end
    wait_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if ({done_a, tmo_a, match_a} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_clear_a: got done/tmo/match %b expected 000",
               {done_a, tmo_a, match_a});
    end
    repeat (2) tick();
    checks++;
    if ({done_a, tmo_a, match_a} !== 3'b101) begin
      errors++;
      $display("FAIL recheck_after_timeout_a: got done/tmo/match %b expected 101",
               {done_a, tmo_a, match_a});
    end
  endtask

  // L=2, 3 stalls on TS: RD_ID 1 + LAT 2 + RD_TS 4 + LAT 2 = 9 cycles.
  task automatic test_latency_stall();
    start_b = 1'b1;
    tick();                       // 1: RD_ID
    start_b = 1'b0;
    repeat (3) tick();            // 4: RD_TS
    wait_b = 1'b1;
    checks++;
    if ({read_b, addr_b, busy_b} !== 3'b111) begin
      errors++;
      $display("FAIL lat_rd_ts_b: got read/addr/busy %b expected 111", {read_b, addr_b, busy_b});
    end
    repeat (3) tick();            // 7: last RD_TS cycle
    wait_b = 1'b0;
    checks++;
    if ({read_b, addr_b} !== 2'b11) begin
      errors++;
      $display("FAIL lat_stall_hold_b: got read/addr %b expected 11", {read_b, addr_b});
    end
    tick();                       // 8: LAT_TS
    checks++;
    if ({read_b, busy_b, done_b} !== 3'b010) begin
      errors++;
      $display("FAIL lat_ts_b: got read/busy/done %b expected 010", {read_b, busy_b, done_b});
    end
    tick();
    checks++;
    if (done_b !== 1'b0) begin
      errors++;
      $display("FAIL lat_early_done_b: got %b expected 0", done_b);
    end
    tick();                       // 10: DONE
    checks++;
    if ({done_b, match_b, tmo_b} !== 3'b110 || ts_b !== ExpTs || id_b !== ExpId) begin
      errors++;
      $display("FAIL lat_done_b: got done/match/tmo %b words %h/%h expected 110 %h/%h",
               {done_b, match_b, tmo_b}, id_b, ts_b, ExpId, ExpTs);
    end
  endtask

  task automatic test_reset_mid_read();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (4) tick();            // 5: LAT_TS
    checks++;
    if ({read_b, busy_b, addr_b} !== 3'b010) begin
      errors++;
      $display("FAIL mid_lat_ts_b: got read/busy/addr %b expected 010", {read_b, busy_b, addr_b});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({done_b, match_b, tmo_b, busy_b, read_b, addr_b} !== 6'b0 ||
        id_b !== 32'd0 || ts_b !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_b: got flags %b words %h/%h expected all 0",
               {done_b, match_b, tmo_b, busy_b, read_b, addr_b}, id_b, ts_b);
    end
    checks++;
    if ({done_a, match_a, busy_a} !== 3'b000 || id_a !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_a: got done/match/busy %b id %h expected 000 0",
               {done_a, match_a, busy_a}, id_a);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (7) tick();
    checks++;
    if ({done_b, match_b, done_a, match_a} !== 4'b1111) begin
      errors++;
      $display("FAIL rerun_after_reset: got done_b/match_b/done_a/match_a %b expected 1111",
               {done_b, match_b, done_a, match_a});
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
`ifdef SYSID_CHECK_PERIODIC_EN
    test_periodic();
`endif
    test_id_mismatch();
    test_start_while_busy();
    test_timeout();
    test_latency_stall();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_system_sysid_checker.md
# soc_system_sysid_checker

Avalon-MM read master that sits directly downstream of the system-ID slave and consumes its two read words: address 0 (system ID) and address 1 (build timestamp). After reset release, or on request, it reads both words, stores them, and compares them against build-time expected values. It produces `done`, `match` and `timeout` status for the boot/health logic and LEDs, so a mismatched FPGA image is flagged in hardware without HPS software.

## Interface
- `EXPECTED_ID`, 32'hACD51302: required word at address 0.
- `EXPECTED_TS`, 32'h55F060DF: required word at address 1.
- `READ_LATENCY`, 0: fixed slave read latency in cycles, legal range 0..3.
- `TIMEOUT_CYCLES`, 255: maximum stall cycles per read; legal range 1..65535.
- `PERIOD_CYCLES`, 1000000: re-check interval; used only with the macro below.
- `clock` in 1: single clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse requesting a check.
- `avm_address` out 1: 0 = ID, 1 = timestamp.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: interconnect stall.
- `avm_readdata` in 32: slave read data.
- `id_value` out 32: captured ID.
- `ts_value` out 32: captured timestamp.
- `busy` out 1: check in progress.
- `done` out 1: last check finished. Level output; stays high until the next check starts.
- `match` out 1: both words equal their expected values. Valid only while `done` is high.
- `timeout` out 1: the last check aborted because of a stall.
- `mismatch_sticky` out 1: a failure has occurred since reset. Tied to 0 when the macro is undefined.

## Operation
- FSM states are IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS and DONE.
- Reset values:
  - All outputs are 0, including `id_value` and `ts_value`.
  - The FSM is in IDLE.
- Auto-start: IDLE moves to RD_ID on the first clock after `reset_n` deasserts. `start` is not needed.
- RD_x state:
  - Drive `avm_read`=1 and `avm_address` = 0 for ID, 1 for TS.
  - Hold both outputs stable while `avm_waitrequest`=1.
  - A read is accepted when `avm_read` & !`avm_waitrequest`.
- Capture of `avm_readdata`:
  - READ_LATENCY=0: capture in the accept cycle, then go straight to the next RD state, or to DONE.
  - READ_LATENCY=L>0: go to LAT_x with `avm_read`=0. Count L cycles and capture on the L-th cycle after the accept.
- The block issues exactly one outstanding read at a time. ID is always read before TS.
- Timeout:
  - A 16-bit stall counter is cleared on entry to each RD state and increments on each RD cycle with `avm_waitrequest`=1.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE with `timeout`=1 and `match`=0. The captured value for that address is left unchanged.
- DONE state:
  - `done`=1, `busy`=0.
  - `match` = (`id_value`==EXPECTED_ID) & (`ts_value`==EXPECTED_TS) & !`timeout`, registered on DONE entry.
- `start` handling:
  - A pulse in DONE restarts the check at RD_ID. `done`, `match` and `timeout` clear on the cycle RD_ID is entered.
  - A pulse while `busy` is ignored; it is not queued.
- If `reset_n` asserts mid-read, everything returns immediately to reset values. A late data word from the slave is not captured.

## Timing
- `busy` is high in every state except IDLE and DONE.
- Zero-wait, READ_LATENCY=0: RD_ID and RD_TS take 1 cycle each. `done` rises on the 3rd clock after reset release.
- General total latency: 2×(1+W+L) cycles from RD_ID entry to DONE, where W = stall cycles and L = READ_LATENCY.
- All outputs are registered. None depend combinationally on `avm_waitrequest` or `avm_readdata`.

## Configuration
- Macro: `SYSID_CHECK_PERIODIC_EN`.
- Defined:
  - A 32-bit period counter runs while in DONE. It reaches PERIOD_CYCLES−1 and restarts the check as if `start` had pulsed, then clears.
  - `mismatch_sticky` sets on any DONE entry with `match`=0 and clears only on reset.
- Undefined: no period counter. DONE is left only by `start`. `mismatch_sticky` is constant 0.

## Structure
- Shared package `soc_system_sysid_pkg` holds:
  - the FSM state enum;
  - address constants `SYSID_ADDR_ID`=0 and `SYSID_ADDR_TS`=1;
  - the default expected-value constants.
- Natural sub-module: `soc_system_sysid_rd_seq`. It owns the single-read handshake: accept detect, latency counter, stall/timeout counter, and capture strobe. The top module holds the FSM and the compare logic.

## Test plan
- Reset release, slave returns 0xACD51302 and 0x55F060DF with zero wait, L=0 → `done`=1, `match`=1, `timeout`=0 on the 3rd clock.
- Slave returns ID 0xACD51303 → `done`=1, `match`=0, `id_value`=0xACD51303, `mismatch_sticky`=1 (with macro).
- `avm_waitrequest` held high, TIMEOUT_CYCLES=8 → `avm_address`=0 stable for 8 cycles, then `timeout`=1, `match`=0, `done`=1.
- READ_LATENCY=2, 3 stall cycles on TS read → TS captured exactly 2 cycles after accept; `done` rises 2×3+3 cycles after RD_ID entry.
- `start` pulsed while busy → ignored. `start` in DONE → `done` clears next cycle and both addresses are reread in order.
- With macro, PERIOD_CYCLES=16 → a new check starts 16 cycles after DONE entry. `reset_n` asserted during LAT_TS → all outputs read 0 asynchronously.
